// File: rtl/cdc_hs_tx.sv
// Source-side launcher for a 4-phase REQ/ACK multi-bit crossing; ACK is resynchronised locally.
// Optional handshake watchdog enabled by defining CDC_HS_TIMEOUT_EN.
`timescale 1ns/1ps
module cdc_hs_tx #(
  parameter int BUS_WIDTH      = 8,
  parameter int STAGES_NUM     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] DATA_IN,
  input  logic                 DATA_VALID,
  input  logic                 ACK_ASYNC,
  output logic                 REQ_OUT,
  output logic [BUS_WIDTH-1:0] DATA_OUT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR
);

  if (STAGES_NUM < 2 || STAGES_NUM > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("cdc_hs_tx: STAGES_NUM must be 2..4 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, REQ_HI, ACK_LO} state_t;

  state_t                 state_q, state_d;
  logic [STAGES_NUM-1:0]  ack_sync_q;
  logic                   ack_s;
  logic                   tmo;
  logic                   req_q, req_d;
  logic                   done_q, done_d;
  logic [BUS_WIDTH-1:0]   data_q, data_d;

  // ACK_ASYNC goes only into the first synchroniser flop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ack_sync_q <= '0;
    else     ack_sync_q <= {ack_sync_q[STAGES_NUM-2:0], ACK_ASYNC};
  end

  assign ack_s = ack_sync_q[STAGES_NUM-1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (DATA_VALID) state_d = REQ_HI;
      REQ_HI:  if (ack_s) state_d = ACK_LO;
               else if (tmo) state_d = IDLE;
      ACK_LO:  if (!ack_s || tmo) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d  = req_q;
    data_d = data_q;
    done_d = 1'b0;
    case (state_q)
      IDLE:    if (DATA_VALID) begin
                 req_d  = 1'b1;
                 data_d = DATA_IN;
               end
      REQ_HI:  if (ack_s || tmo) req_d = 1'b0;
      ACK_LO:  done_d = !ack_s;
      default: req_d = 1'b0;
    endcase
  end

`ifdef CDC_HS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;

  // Counter restarts whenever the FSM enters a waiting state.
  assign tmo   = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign cnt_d = (state_q != IDLE && state_d == state_q) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= tmo && (state_d == IDLE) && !done_d;
    end
  end

  assign ERR = err_q;
`else
  assign tmo = 1'b0;
  assign ERR = 1'b0;
`endif

  assign REQ_OUT  = req_q;
  assign DATA_OUT = data_q;
  assign DONE     = done_q;
  assign BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed bench for cdc_hs_tx with STAGES_NUM=2, BUS_WIDTH=8, TIMEOUT_CYCLES=8.
`timescale 1ns/1ps
module tb_cdc_hs_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       ack_async = 1'b0;
  logic       req_out;
  logic [7:0] data_out;
  logic       busy, done, err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cdc_hs_tx #(
    .BUS_WIDTH(8),
    .STAGES_NUM(2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .DATA_IN(data_in),
    .DATA_VALID(data_valid),
    .ACK_ASYNC(ack_async),
    .REQ_OUT(req_out),
    .DATA_OUT(data_out),
    .BUSY(busy),
    .DONE(done),
    .ERR(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int dn, bad, rq;

    // Reset state
    step(1);
    check("rst_req", req_out, 0);
    check("rst_data", data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    step(2);

    // Basic transfer
    data_in = 8'hA5; data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    check("basic_req_rise", req_out, 1);
    check("basic_data", data_out, 8'hA5);
    check("basic_busy0", busy, 1);
    step(2);
    ack_async = 1'b1;
    step(1); check("basic_req_hold1", req_out, 1);
    step(1); check("basic_req_hold2", req_out, 1);
    step(1); check("basic_req_fall", req_out, 0);
    check("basic_busy1", busy, 1);
    check("basic_data_hold", data_out, 8'hA5);
    step(2);
    ack_async = 1'b0;
    step(1); check("basic_done_early1", done, 0);
    check("basic_busy2", busy, 1);
    step(1); check("basic_done_early2", done, 0);
    step(1); check("basic_done", done, 1);
    check("basic_idle", busy, 0);
    step(1); check("basic_done_pulse", done, 0);
    step(2);

    // Busy drop: a second request while in REQ_HI is discarded
    data_in = 8'h11; data_valid = 1'b1;
    step(1);
    check("drop_data11", data_out, 8'h11);
    data_in = 8'h3C;
    step(2);
    data_valid = 1'b0;
    check("drop_data_kept", data_out, 8'h11);
    ack_async = 1'b1;
    step(3);
    check("drop_req_fall", req_out, 0);
    ack_async = 1'b0;
    dn = 0; rq = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (done) dn++;
      if (req_out) rq++;
    end
    check("drop_one_done", dn, 1);
    check("drop_no_req", rq, 0);
    check("drop_data_final", data_out, 8'h11);

    // Back-to-back with destination echoing REQ as ACK
    data_in = 8'h01; data_valid = 1'b1;
    step(1);
    check("b2b_first_data", data_out, 8'h01);
    data_in = 8'h02;
    ack_async = req_out;
    dn = 0;
    for (int i = 2; i <= 16; i++) begin
      step(1);
      if (i == 7) begin
        check("b2b_first_done", done, 1);
        check("b2b_req_low_at_done", req_out, 0);
        check("b2b_data_at_done", data_out, 8'h01);
      end
      if (i == 8) begin
        check("b2b_second_req", req_out, 1);
        check("b2b_second_data", data_out, 8'h02);
        data_valid = 1'b0;
      end
      if (done) dn++;
      ack_async = req_out;
    end
    check("b2b_two_done", dn, 2);
    check("b2b_idle", busy, 0);
    ack_async = 1'b0;
    step(3);

    // Asynchronous reset mid-transfer
    data_in = 8'h5A; data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    check("arst_pre_req", req_out, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_req", req_out, 0);
    check("arst_busy", busy, 0);
    check("arst_data", data_out, 0);
    check("arst_done", done, 0);
    #1 rst = 1'b0;
    dn = 0; rq = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (done) dn++;
      if (req_out) rq++;
    end
    check("arst_no_done", dn, 0);
    check("arst_no_req", rq, 0);

    // Spurious ACK while idle
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      ack_async = (i < 4);
      step(1);
      if (req_out || busy || done) bad++;
    end
    check("spurious_ack", bad, 0);
    ack_async = 1'b0;
    step(2);

`ifdef CDC_HS_TIMEOUT_EN
    // Timeout: ACK never returned
    data_in = 8'h77; data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    bad = 0;
    for (int i = 2; i <= 8; i++) begin
      step(1);
      if (!req_out || err) bad++;
    end
    check("tmo_wait", bad, 0);
    step(1);
    check("tmo_req_fall", req_out, 0);
    check("tmo_err", err, 1);
    check("tmo_done", done, 0);
    check("tmo_busy", busy, 0);
    step(1);
    check("tmo_err_pulse", err, 0);
    data_in = 8'h88; data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    check("tmo_new_req", req_out, 1);
    check("tmo_new_data", data_out, 8'h88);
`else
    // No watchdog: REQ held indefinitely
    data_in = 8'h77; data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
    rq = 0; bad = 0;
    for (int i = 0; i < 120; i++) begin
      step(1);
      if (req_out) rq++;
      if (err) bad++;
    end
    check("notmo_req_held", rq, 120);
    check("notmo_no_err", bad, 0);
    check("notmo_data", data_out, 8'h77);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cdc_hs_tx.md
Name: cdc_hs_tx

Overview:
- Source-domain launcher for multi-bit clock-domain crossings using a 4-phase REQ/ACK handshake.
- Captures a data word, holds it stable on DATA_OUT and raises REQ_OUT toward the destination domain.
- Synchronizes the returning ACK_ASYNC with an internal multi-flop bit synchronizer, then completes the handshake.
- Pairs with the destination-side REQ synchronizer/capture block.

Parameters:
- BUS_WIDTH, 8, width of the transferred data word.
- STAGES_NUM, 2, flop stages in the ACK synchronizer; legal range 2..4.
- TIMEOUT_CYCLES, 64, handshake timeout in CLK cycles; used only with CDC_HS_TIMEOUT_EN.

Ports:
- CLK  in  1  source-domain clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- DATA_IN  in  BUS_WIDTH  word to transfer.
- DATA_VALID  in  1  transfer request; accepted only in IDLE.
- ACK_ASYNC  in  1  acknowledge from the destination domain; asynchronous to CLK.
- REQ_OUT  out  1  registered request to the destination domain.
- DATA_OUT  out  BUS_WIDTH  registered data; stable for the whole time REQ_OUT is high.
- BUSY  out  1  high while state != IDLE.
- DONE  out  1  one-cycle pulse when a handshake completes.
- ERR  out  1  one-cycle timeout pulse; tied 0 without the macro.

Behaviour:
- Reset (async, active-high): state=IDLE; REQ_OUT=0, DATA_OUT=0, DONE=0, ERR=0; all ACK sync flops=0; timeout counter=0. BUSY=0.
- ACK synchronizer: a chain of STAGES_NUM flops. ack_s is the last stage. ACK_ASYNC must not feed any other logic.
- FSM states: IDLE, REQ_HI, ACK_LO.
- IDLE: if DATA_VALID=1 at a rising edge, then at that edge DATA_OUT<=DATA_IN, REQ_OUT<=1, and state goes to REQ_HI. Otherwise DATA_OUT holds its last value.
- REQ_HI: wait for ack_s=1. At that edge REQ_OUT<=0 and state goes to ACK_LO.
- ACK_LO: wait for ack_s=0. At that edge DONE<=1 for one cycle and state goes to IDLE.
- Latency: ACK_ASYNC rising, set up before edge k+1, causes REQ_OUT to fall at edge k+STAGES_NUM+1. ACK falling behaves symmetrically and produces DONE.
- DATA_VALID while BUSY=1 is ignored and not queued; the upstream block must respect BUSY.
- DATA_VALID in the cycle DONE is high: IDLE is already reached, so the word is accepted and a back-to-back transfer starts.
- DATA_OUT changes only on acceptance in IDLE, never while REQ_OUT=1.
- ack_s=1 while in IDLE (spurious or stale ACK): ignored; no state change.
- Reset mid-transfer: REQ_OUT drops immediately and the transfer is lost. The destination must tolerate an abandoned REQ.
- DONE and ERR are never high in the same cycle.

Optional Feature:
- Macro CDC_HS_TIMEOUT_EN.
- When defined: a counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to REQ_HI or ACK_LO and increments each cycle spent in those states. When it reaches TIMEOUT_CYCLES, at that edge: REQ_OUT<=0, ERR<=1 for one cycle, counter cleared, state goes to IDLE, DONE stays 0.
- When undefined: no counter logic; ERR is constant 0; the FSM waits indefinitely.

Test Plan (STAGES_NUM=2, BUS_WIDTH=8):
- Basic transfer: DATA_IN=8'hA5 with a 1-cycle DATA_VALID; ACK_ASYNC raised 3 cycles after REQ_OUT and lowered 3 cycles after REQ_OUT falls.
  - DATA_OUT=A5 and REQ_OUT=1 from the edge after acceptance.
  - REQ_OUT falls 3 edges after ACK rises.
  - DONE pulses once, 3 edges after ACK falls.
  - BUSY is high throughout.
- Busy drop: DATA_VALID with 8'h3C while in REQ_HI carrying 8'h11 -> DATA_OUT stays 11; exactly one DONE; no second REQ.
- Back-to-back: DATA_VALID held high with DATA_IN 8'h01 then 8'h02 -> two complete handshakes; the second REQ_OUT rises on the edge after the first DONE.
- Async reset: RST pulsed mid-REQ_HI, not edge-aligned -> REQ_OUT, BUSY and DATA_OUT go to 0 immediately, with no DONE pulse.
- Spurious ACK: ACK_ASYNC pulsed high for 4 cycles while IDLE -> REQ_OUT, BUSY and DONE stay 0.
- Timeout (macro defined, TIMEOUT_CYCLES=8): ACK never returned -> exactly 8 cycles after entry to REQ_HI, REQ_OUT=0 and a 1-cycle ERR pulse occurs; the block then accepts a new DATA_VALID. With the macro undefined, REQ_OUT stays high for more than 100 cycles.
